// File: rtl/muon_pkg.sv
// rtl/muon_pkg.sv - shared constants for the muon lifetime datapath
package muon_pkg;

  // Width of every run statistics counter and of the elapsed-tick counter
  localparam int CNT_W = 16;

  // Defaults shared with tdc_measurement
  localparam int TIMEOUT_DEFAULT = 660;
  localparam int DEAD_DEFAULT    = 100;

  // Sequencer state encoding, visible on state_o
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_EMIT    = 3'd3;
  localparam logic [2:0] ST_DEAD    = 3'd4;

endpackage

// File: rtl/muon_run_controller_sat_counter.sv
// rtl/muon_run_controller_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter
  import muon_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear wins over increment; increment stops once every bit is set
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/muon_run_controller.sv
// rtl/muon_run_controller.sv - run window, start/stop timing, dead time and event stream
module muon_run_controller
  import muon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int DEAD_CYCLES    = DEAD_DEFAULT,
  parameter int TICK_DIV       = 100_000_000,
  parameter int TIME_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run_start,
  input  logic              run_stop,
  input  logic [15:0]       run_len,
  input  logic              start_pulse,
  input  logic              stop_pulse,
  output logic              evt_valid,
  output logic [TIME_W-1:0] evt_time,
  input  logic              evt_ready,
  output logic              running,
  output logic [2:0]        state_o,
  output logic [15:0]       elapsed,
  output logic [15:0]       n_starts,
  output logic [15:0]       n_decays,
  output logic [15:0]       n_timeouts,
  output logic [15:0]       n_dropped
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]     DEAD_LAST  = DW'(DEAD_CYCLES - 1);
  localparam logic [TIME_W-1:0] TCNT_LAST  = TIME_W'(TIMEOUT_CYCLES);

  logic [2:0]        state_q, state_d;
  logic [TIME_W-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0]     dead_q, dead_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              end_q, end_d;
  logic              running_q, running_d;
  logic              evt_valid_q, evt_valid_d;
  logic [TIME_W-1:0] evt_time_q, evt_time_d;

  logic end_req;
  logic end_pend;
  logic clr_cnt;
  logic inc_starts, inc_decays, inc_timeouts, inc_dropped, inc_elapsed;

  // Sequencer: run window, measurement timing, hand-off and hold-off
  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    dead_d       = dead_q;
    presc_d      = presc_q;
    end_d        = end_q;
    running_d    = running_q;
    evt_valid_d  = evt_valid_q;
    evt_time_d   = evt_time_q;
    clr_cnt      = 1'b0;
    inc_starts   = 1'b0;
    inc_decays   = 1'b0;
    inc_timeouts = 1'b0;
    inc_dropped  = 1'b0;
    inc_elapsed  = 1'b0;

    // The end flag outlives running so a pending event can still drain to IDLE
    end_req  = running_q && (run_stop || ((run_len != '0) && (elapsed == run_len)));
    end_pend = end_q || end_req;
    if (end_req) begin
      end_d     = 1'b1;
      running_d = 1'b0;
    end

    if (running_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d     = '0;
        inc_elapsed = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels the start
        if (run_start && !run_stop) begin
          clr_cnt   = 1'b1;
          presc_d   = '0;
          end_d     = 1'b0;
          running_d = 1'b1;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (end_pend) begin
          state_d = ST_IDLE;
        end else if (start_pulse) begin
          inc_starts = 1'b1;
          tcnt_d     = TIME_W'(1);
          state_d    = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // Stop beats timeout on the last counted cycle; a run end discards the measurement
        if (end_pend) begin
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (stop_pulse) begin
          evt_time_d  = tcnt_q;
          evt_valid_d = 1'b1;
          inc_decays  = 1'b1;
          tcnt_d      = '0;
          state_d     = ST_EMIT;
        end else if (tcnt_q == TCNT_LAST) begin
          inc_timeouts = 1'b1;
          tcnt_d       = '0;
          dead_d       = '0;
          state_d      = ST_DEAD;
        end else begin
          tcnt_d = tcnt_q + TIME_W'(1);
        end
      end
      ST_EMIT: begin
        if (start_pulse) begin
          inc_dropped = 1'b1;
        end
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
          dead_d      = '0;
          state_d     = end_pend ? ST_IDLE : ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (start_pulse) begin
          inc_dropped = 1'b1;
        end
        if (end_pend) begin
          state_d = ST_IDLE;
        end else if (dead_q == DEAD_LAST) begin
          state_d = ST_ARMED;
        end else begin
          dead_d = dead_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      dead_q      <= '0;
      presc_q     <= '0;
      end_q       <= 1'b0;
      running_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_time_q  <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      dead_q      <= dead_d;
      presc_q     <= presc_d;
      end_q       <= end_d;
      running_q   <= running_d;
      evt_valid_q <= evt_valid_d;
      evt_time_q  <= evt_time_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_elapsed (
    .clk(clk), .rst_n(reset_n), .clr(clr_cnt), .inc(inc_elapsed), .q(elapsed)
  );
  sat_counter #(.W(CNT_W)) u_starts (
    .clk(clk), .rst_n(reset_n), .clr(clr_cnt), .inc(inc_starts), .q(n_starts)
  );
  sat_counter #(.W(CNT_W)) u_decays (
    .clk(clk), .rst_n(reset_n), .clr(clr_cnt), .inc(inc_decays), .q(n_decays)
  );
  sat_counter #(.W(CNT_W)) u_timeouts (
    .clk(clk), .rst_n(reset_n), .clr(clr_cnt), .inc(inc_timeouts), .q(n_timeouts)
  );
  sat_counter #(.W(CNT_W)) u_dropped (
    .clk(clk), .rst_n(reset_n), .clr(clr_cnt), .inc(inc_dropped), .q(n_dropped)
  );

  assign evt_valid = evt_valid_q;
  assign evt_time  = evt_time_q;
  assign running   = running_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_muon_run_controller.sv
// tb/tb_muon_run_controller.sv - self-checking bench for muon_run_controller
module tb_muon_run_controller;

  localparam int TO = 660;
  localparam int DC = 100;
  localparam int TD = 10;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_MEASURE = 3'd2, S_EMIT = 3'd3, S_DEAD = 3'd4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run_start = 1'b0, run_stop = 1'b0;
  logic [15:0] run_len = '0;
  logic start_pulse = 1'b0, stop_pulse = 1'b0, evt_ready = 1'b0;
  logic evt_valid, running;
  logic [15:0] evt_time, elapsed, n_starts, n_decays, n_timeouts, n_dropped;
  logic [2:0] state_o;
  logic sat_clr = 1'b0, sat_inc = 1'b0;
  logic [2:0] sat_q;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_starts = 0, exp_decays = 0, exp_timeouts = 0, exp_dropped = 0;

  always #5 clk = ~clk;

  muon_run_controller #(.TIMEOUT_CYCLES(TO), .DEAD_CYCLES(DC), .TICK_DIV(TD), .TIME_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .run_start(run_start), .run_stop(run_stop), .run_len(run_len),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .evt_valid(evt_valid), .evt_time(evt_time),
    .evt_ready(evt_ready), .running(running), .state_o(state_o), .elapsed(elapsed),
    .n_starts(n_starts), .n_decays(n_decays), .n_timeouts(n_timeouts), .n_dropped(n_dropped)
  );

  sat_counter #(.W(3)) u_sat (.clk(clk), .rst_n(reset_n), .clr(sat_clr), .inc(sat_inc), .q(sat_q));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_armed(input int limit, output int cycles);
    cycles = 0;
    while (state_o != S_ARMED && cycles < limit) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic begin_run(input logic [15:0] len);
    run_len = len;
    run_start = 1'b1;
    step(1);
    run_start = 1'b0;
    exp_starts = 0; exp_decays = 0; exp_timeouts = 0; exp_dropped = 0;
    n_cmp++;
    if (running !== 1'b1 || state_o !== S_ARMED) begin
      n_bad++; $display("FAIL run_start: running=%0b state=%0d, want 1/%0d", running, state_o, S_ARMED);
    end
    n_cmp++;
    if ({elapsed, n_starts, n_decays, n_timeouts, n_dropped} !== 80'd0) begin
      n_bad++; $display("FAIL run_clear: el=%0d s=%0d d=%0d t=%0d x=%0d, want all 0", elapsed, n_starts, n_decays, n_timeouts, n_dropped);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(2);
    n_cmp++;
    if (evt_valid !== 1'b0 || running !== 1'b0 || state_o !== S_IDLE || evt_time !== 16'd0) begin
      n_bad++; $display("FAIL reset_ctrl: v=%0b r=%0b st=%0d t=%0d, want 0/0/0/0", evt_valid, running, state_o, evt_time);
    end
    n_cmp++;
    if ({elapsed, n_starts, n_decays, n_timeouts, n_dropped} !== 80'd0) begin
      n_bad++; $display("FAIL reset_counters: el=%0d s=%0d d=%0d t=%0d x=%0d, want all 0", elapsed, n_starts, n_decays, n_timeouts, n_dropped);
    end
    reset_n = 1'b1;
    start_pulse = 1'b1;
    step(2);
    start_pulse = 1'b0;
    n_cmp++;
    if (state_o !== S_IDLE || n_starts !== 16'd0) begin
      n_bad++; $display("FAIL idle_ignores_start: state=%0d starts=%0d, want %0d/0", state_o, n_starts, S_IDLE);
    end
  endtask

  task automatic test_basic;
    int c;
    begin_run(16'd0);
    evt_ready = 1'b1;
    start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_starts++;
    step(36);
    stop_pulse = 1'b1; step(1); stop_pulse = 1'b0; exp_decays++;
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_time !== 16'd37) begin
      n_bad++; $display("FAIL basic_event: valid=%0b time=%0d, want 1/37", evt_valid, evt_time);
    end
    step(1);
    n_cmp++;
    if (evt_valid !== 1'b0 || state_o !== S_DEAD) begin
      n_bad++; $display("FAIL basic_one_cycle: valid=%0b state=%0d, want 0/%0d", evt_valid, state_o, S_DEAD);
    end
    n_cmp++;
    if (n_starts !== 16'(exp_starts) || n_decays !== 16'(exp_decays)) begin
      n_bad++; $display("FAIL basic_counts: starts=%0d decays=%0d, want %0d/%0d", n_starts, n_decays, exp_starts, exp_decays);
    end
    evt_ready = 1'b0;
    wait_armed(300, c);
    n_cmp++;
    if (c != DC) begin
      n_bad++; $display("FAIL basic_dead: %0d cycles to re-arm, want %0d", c, DC);
    end
  endtask

  task automatic test_timeout;
    int c, vbad;
    vbad = 0;
    start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_starts++;
    for (int j = 0; j < TO - 1; j++) begin
      step(1);
      if (evt_valid !== 1'b0) vbad++;
    end
    n_cmp++;
    if (state_o !== S_MEASURE || vbad != 0) begin
      n_bad++; $display("FAIL timeout_pending: state=%0d stray_valid=%0d, want %0d/0", state_o, vbad, S_MEASURE);
    end
    step(1); exp_timeouts++;
    n_cmp++;
    if (state_o !== S_DEAD || n_timeouts !== 16'(exp_timeouts) || evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_dead: state=%0d timeouts=%0d valid=%0b, want %0d/%0d/0", state_o, n_timeouts, evt_valid, S_DEAD, exp_timeouts);
    end
    step(49);
    start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_dropped++;
    n_cmp++;
    if (n_dropped !== 16'(exp_dropped) || n_starts !== 16'(exp_starts) || state_o !== S_DEAD) begin
      n_bad++; $display("FAIL dead_drop: dropped=%0d starts=%0d state=%0d, want %0d/%0d/%0d", n_dropped, n_starts, state_o, exp_dropped, exp_starts, S_DEAD);
    end
    wait_armed(300, c);
    n_cmp++;
    if (c != DC - 50) begin
      n_bad++; $display("FAIL timeout_rearm: %0d cycles, want %0d", c, DC - 50);
    end
  endtask

  task automatic test_stall;
    int c, k, vbad;
    k = $urandom_range(1, TO);
    vbad = 0;
    evt_ready = 1'b0;
    start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_starts++;
    step(k - 1);
    stop_pulse = 1'b1; step(1); stop_pulse = 1'b0; exp_decays++;
    for (int j = 0; j < 200; j++) begin
      if (evt_valid !== 1'b1 || evt_time !== 16'(k)) vbad++;
      start_pulse = (j == 100);
      step(1);
    end
    start_pulse = 1'b0; exp_dropped++;
    n_cmp++;
    if (vbad != 0 || evt_valid !== 1'b1 || evt_time !== 16'(k) || state_o !== S_EMIT) begin
      n_bad++; $display("FAIL stall_stable: unstable=%0d valid=%0b time=%0d, want 0/1/%0d", vbad, evt_valid, evt_time, k);
    end
    n_cmp++;
    if (n_dropped !== 16'(exp_dropped)) begin
      n_bad++; $display("FAIL emit_drop: dropped=%0d, want %0d", n_dropped, exp_dropped);
    end
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0 || state_o !== S_DEAD) begin
      n_bad++; $display("FAIL stall_transfer: valid=%0b state=%0d, want 0/%0d", evt_valid, state_o, S_DEAD);
    end
    wait_armed(300, c);
    n_cmp++;
    if (c != DC) begin
      n_bad++; $display("FAIL stall_rearm: %0d cycles, want %0d", c, DC);
    end
  endtask

  task automatic test_boundary;
    int c, k;
    start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_starts++;
    step(TO - 1);
    stop_pulse = 1'b1; step(1); stop_pulse = 1'b0; exp_decays++;
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_time !== 16'(TO) || n_timeouts !== 16'(exp_timeouts)) begin
      n_bad++; $display("FAIL stop_at_limit: valid=%0b time=%0d timeouts=%0d, want 1/%0d/%0d", evt_valid, evt_time, n_timeouts, TO, exp_timeouts);
    end
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    wait_armed(300, c);
    k = $urandom_range(2, 50);
    start_pulse = 1'b1; stop_pulse = 1'b1; step(1); start_pulse = 1'b0; stop_pulse = 1'b0; exp_starts++;
    n_cmp++;
    if (state_o !== S_MEASURE || evt_valid !== 1'b0 || n_decays !== 16'(exp_decays)) begin
      n_bad++; $display("FAIL same_cycle: state=%0d valid=%0b decays=%0d, want %0d/0/%0d", state_o, evt_valid, n_decays, S_MEASURE, exp_decays);
    end
    step(k - 1);
    stop_pulse = 1'b1; step(1); stop_pulse = 1'b0; exp_decays++;
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_time !== 16'(k)) begin
      n_bad++; $display("FAIL same_cycle_time: valid=%0b time=%0d, want 1/%0d", evt_valid, evt_time, k);
    end
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    wait_armed(300, c);
  endtask

  task automatic test_random;
    int c, k, dly, drop_at, vbad, remain;
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(1, TO + 40);
      dly = $urandom_range(0, 6);
      drop_at = $urandom_range(0, DC - 1);
      vbad = 0;
      start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_starts++;
      if (k <= TO) begin
        step(k - 1);
        stop_pulse = 1'b1; step(1); stop_pulse = 1'b0; exp_decays++;
        for (int j = 0; j < dly; j++) begin
          if (evt_valid !== 1'b1 || evt_time !== 16'(k)) vbad++;
          step(1);
        end
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_time !== 16'(k) || vbad != 0) begin
          n_bad++; $display("FAIL rnd_event[%0d]: valid=%0b time=%0d unstable=%0d, want 1/%0d/0", it, evt_valid, evt_time, vbad, k);
        end
        evt_ready = 1'b1; step(1); evt_ready = 1'b0;
      end else begin
        for (int j = 0; j < TO; j++) begin
          step(1);
          if (evt_valid !== 1'b0) vbad++;
        end
        exp_timeouts++;
        n_cmp++;
        if (vbad != 0) begin
          n_bad++; $display("FAIL rnd_timeout_valid[%0d]: stray valid cycles=%0d, want 0", it, vbad);
        end
      end
      n_cmp++;
      if (state_o !== S_DEAD || evt_valid !== 1'b0) begin
        n_bad++; $display("FAIL rnd_dead[%0d]: state=%0d valid=%0b, want %0d/0", it, state_o, evt_valid, S_DEAD);
      end
      remain = DC;
      if (drop_at != 0) begin
        step(drop_at - 1);
        start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_dropped++;
        remain = DC - drop_at;
      end
      wait_armed(300, c);
      n_cmp++;
      if (c != remain) begin
        n_bad++; $display("FAIL rnd_rearm[%0d]: %0d cycles, want %0d", it, c, remain);
      end
      n_cmp++;
      if (n_starts !== 16'(exp_starts) || n_decays !== 16'(exp_decays) || n_timeouts !== 16'(exp_timeouts) || n_dropped !== 16'(exp_dropped)) begin
        n_bad++; $display("FAIL rnd_counts[%0d]: s=%0d d=%0d t=%0d x=%0d, want %0d/%0d/%0d/%0d", it, n_starts, n_decays, n_timeouts, n_dropped, exp_starts, exp_decays, exp_timeouts, exp_dropped);
      end
    end
  endtask

  task automatic test_idle_hold;
    run_stop = 1'b1; step(1); run_stop = 1'b0;
    n_cmp++;
    if (state_o !== S_IDLE || running !== 1'b0) begin
      n_bad++; $display("FAIL run_stop_armed: state=%0d running=%0b, want %0d/0", state_o, running, S_IDLE);
    end
    start_pulse = 1'b1; stop_pulse = 1'b1; step(1); start_pulse = 1'b0; stop_pulse = 1'b0;
    step(20);
    run_start = 1'b1; run_stop = 1'b1; step(1); run_start = 1'b0; run_stop = 1'b0;
    n_cmp++;
    if (state_o !== S_IDLE || running !== 1'b0) begin
      n_bad++; $display("FAIL start_stop_idle: state=%0d running=%0b, want %0d/0", state_o, running, S_IDLE);
    end
    n_cmp++;
    if (n_starts !== 16'(exp_starts) || n_decays !== 16'(exp_decays) || n_timeouts !== 16'(exp_timeouts) || n_dropped !== 16'(exp_dropped)) begin
      n_bad++; $display("FAIL idle_hold: s=%0d d=%0d t=%0d x=%0d, want %0d/%0d/%0d/%0d", n_starts, n_decays, n_timeouts, n_dropped, exp_starts, exp_decays, exp_timeouts, exp_dropped);
    end
  endtask

  task automatic test_run_len;
    int c;
    begin_run(16'd3);
    c = 0;
    while (running === 1'b1 && c < 200) begin
      step(1);
      c++;
    end
    n_cmp++;
    if (c != 3 * TD + 1 || elapsed !== 16'd3 || state_o !== S_IDLE) begin
      n_bad++; $display("FAIL run_len: cycles=%0d elapsed=%0d state=%0d, want %0d/3/%0d", c, elapsed, state_o, 3 * TD + 1, S_IDLE);
    end
  endtask

  task automatic test_stop_measure;
    begin_run(16'd0);
    start_pulse = 1'b1; step(1); start_pulse = 1'b0; exp_starts++;
    step(10);
    run_stop = 1'b1; step(1); run_stop = 1'b0;
    n_cmp++;
    if (state_o !== S_IDLE || running !== 1'b0 || evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL stop_measure: state=%0d running=%0b valid=%0b, want %0d/0/0", state_o, running, evt_valid, S_IDLE);
    end
    stop_pulse = 1'b1; step(1); stop_pulse = 1'b0;
    step(5);
    n_cmp++;
    if (n_starts !== 16'(exp_starts) || n_decays !== 16'd0 || n_timeouts !== 16'd0 || evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL stop_measure_counts: s=%0d d=%0d t=%0d v=%0b, want %0d/0/0/0", n_starts, n_decays, n_timeouts, evt_valid, exp_starts);
    end
  endtask

  task automatic test_reset_emit;
    begin_run(16'd0);
    evt_ready = 1'b0;
    start_pulse = 1'b1; step(1); start_pulse = 1'b0;
    step(4);
    stop_pulse = 1'b1; step(1); stop_pulse = 1'b0;
    n_cmp++;
    if (state_o !== S_EMIT || evt_time !== 16'd5) begin
      n_bad++; $display("FAIL pre_reset_emit: state=%0d time=%0d, want %0d/5", state_o, evt_time, S_EMIT);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0 || running !== 1'b0 || state_o !== S_IDLE || evt_time !== 16'd0 ||
        {elapsed, n_starts, n_decays, n_timeouts, n_dropped} !== 80'd0) begin
      n_bad++; $display("FAIL async_reset: v=%0b r=%0b st=%0d t=%0d s=%0d d=%0d, want all 0", evt_valid, running, state_o, evt_time, n_starts, n_decays);
    end
    step(2);
    reset_n = 1'b1;
    step(2);
    n_cmp++;
    if (state_o !== S_IDLE || evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset: state=%0d valid=%0b, want %0d/0", state_o, evt_valid, S_IDLE);
    end
  endtask

  task automatic test_saturation;
    int e;
    sat_clr = 1'b1; step(1); sat_clr = 1'b0;
    e = 0;
    for (int i = 0; i < 20; i++) begin
      sat_inc = (i >= 14) || ($urandom_range(0, 3) != 0);
      step(1);
      if (sat_inc) e = (e < 7) ? e + 1 : 7;
      n_cmp++;
      if (sat_q !== 3'(e)) begin
        n_bad++; $display("FAIL sat_count[%0d]: got %0d, want %0d", i, sat_q, e);
      end
    end
    sat_inc = 1'b1; sat_clr = 1'b1; step(1); sat_clr = 1'b0; sat_inc = 1'b0;
    n_cmp++;
    if (sat_q !== 3'd0) begin
      n_bad++; $display("FAIL sat_clear: got %0d, want 0", sat_q);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_stall();
    test_boundary();
    test_random();
    test_idle_hold();
    test_run_len();
    test_stop_measure();
    test_reset_emit();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muon_run_controller.md
# muon_run_controller

Acquisition sequencer for the muon-lifetime datapath. Arms on a coincidence (start) pulse, times the delayed decay (stop) pulse up to a timeout, enforces a dead time, and emits each decay time over a valid/ready stream to downstream histogram/readout logic. Also owns the run window (start/stop/duration) and the run statistics counters that feed the display digits.

## Interface
Parameters:
- TIMEOUT_CYCLES, 660, max start-to-stop interval accepted, in clk cycles
- DEAD_CYCLES, 100, hold-off after each measurement before re-arming
- TICK_DIV, 100_000_000, clk cycles per elapsed-time tick (1 s at 100 MHz)
- TIME_W, 16, width of evt_time; TIMEOUT_CYCLES < 2^TIME_W

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  100 MHz system clock
- reset_n  in  1  async active-low reset
- run_start  in  1  single-cycle pulse: begin run
- run_stop  in  1  single-cycle pulse: end run
- run_len  in  16  run duration in ticks; 0 = unlimited
- start_pulse  in  1  single-cycle coincidence pulse
- stop_pulse  in  1  single-cycle decay pulse
- evt_valid  out  1  decay time available
- evt_time  out  TIME_W  decay time, clk cycles
- evt_ready  in  1  downstream accepts event
- running  out  1  run active
- state_o  out  3  current FSM state (debug)
- elapsed  out  16  ticks elapsed in current run
- n_starts, n_decays, n_timeouts, n_dropped  out  16 each  run statistics

## Operation
- States: IDLE, ARMED, MEASURE, EMIT, DEAD.
- IDLE: run_start -> clear elapsed, prescaler, all four counters; running=1; -> ARMED.
- ARMED: start_pulse -> n_starts+1, tcnt=1, -> MEASURE. stop_pulse alone ignored.
- MEASURE: tcnt+1 per cycle. stop_pulse -> evt_time=tcnt, n_decays+1, -> EMIT. tcnt==TIMEOUT_CYCLES with no stop -> n_timeouts+1, -> DEAD. start_pulse ignored (not counted).
- EMIT: evt_valid=1, evt_time stable until evt_valid&&evt_ready; then -> DEAD. start_pulse while in EMIT or DEAD -> n_dropped+1.
- DEAD: count DEAD_CYCLES cycles, then -> ARMED.
- Run end request: run_stop, or run_len!=0 and elapsed==run_len. Sets end flag; running=0 the next cycle. ARMED/DEAD -> IDLE next cycle. MEASURE -> IDLE, measurement discarded, no counter change. EMIT completes its handshake, then -> IDLE.
- run_start outside IDLE ignored; run_start and run_stop in same IDLE cycle: stop wins (stay IDLE).
- Counters (n_*, elapsed) saturate at 16'hFFFF; hold value in IDLE until next run_start.
- Prescaler runs only while running; elapsed+1 when prescaler reaches TICK_DIV-1.

## Timing
- Reset: state IDLE, running=0, evt_valid=0, evt_time=0, elapsed=0, all n_*=0, tcnt=0.
- start_pulse sampled at edge N, stop_pulse at edge N+k -> evt_time=k, valid k=1..TIMEOUT_CYCLES; evt_valid high from cycle N+k+1.
- start and stop in the same cycle in ARMED: start taken, stop ignored.
- Stop on the cycle tcnt==TIMEOUT_CYCLES: stop wins (decay recorded, no timeout).
- Timeout: no stop through edge N+TIMEOUT_CYCLES -> DEAD at N+TIMEOUT_CYCLES+1.
- Handshake transfer at edge with evt_valid&&evt_ready; DEAD starts next cycle; re-arm DEAD_CYCLES cycles later.
- All outputs registered; no combinational input-to-output paths.
- reset_n asserted mid-run: immediate return to reset values; in-flight event lost.

## Structure
- Shared package muon_pkg: state encoding localparams (IDLE=0, ARMED=1, MEASURE=2, EMIT=3, DEAD=4), CNT_W=16, default TIMEOUT/DEAD constants shared with tdc_measurement.
- One sub-module: sat_counter (16-bit, clear, inc, saturate), instantiated for n_starts, n_decays, n_timeouts, n_dropped and elapsed.
- FSM, tcnt, dead counter and prescaler in the top module.

## Test plan
- Reset then run_start; start_pulse at N, stop_pulse at N+37, evt_ready=1 -> evt_time=37, evt_valid one cycle at N+38, n_starts=1, n_decays=1.
- start_pulse, no stop -> n_timeouts=1 after 660 cycles, no evt_valid; start_pulse 50 cycles into DEAD -> n_dropped=1, no new measurement.
- evt_ready held low 200 cycles after a decay -> evt_valid and evt_time stable for 200 cycles; transfer on ready; DEAD then ARMED after 100 cycles.
- Stop on tcnt==660 -> evt_time=660, n_timeouts=0; start and stop same cycle in ARMED -> measurement begins, stop ignored.
- TICK_DIV=10, run_len=3 -> running drops after 30 cycles, elapsed=3, state IDLE; run_stop during MEASURE -> IDLE, counters unchanged.
- reset_n pulsed low during EMIT -> all outputs zero immediately, state IDLE; counter saturation forced at 16'hFFFF holds.
